// File: rtl/wb_unit_if.sv
// Writeback-stage bus bundle.
// Groups the memory-stage slot (in_*), the long-latency result port (late_*) and the
// register-file write port (wb_*). The master side drives slots and late results and
// sees the ready signals and the write port. The slave side is wb_unit.
// Register-field encodings shared by the stage and its drivers are defined here.

`ifndef WB_UNIT_DEFINES
`define WB_UNIT_DEFINES
`define REG_ADDR_W      5
`define REG_W_SRC_WIDTH 2
`define REG_W_DST_WIDTH 2
`define REG_W_SRC_ALU   2'b00
`define REG_W_SRC_MEM   2'b01
`define REG_W_SRC_PCA4  2'b10
`define REG_W_DST_RD    2'b00
`define REG_W_DST_RT    2'b01
`define REG_W_DST_R31   2'b10
`endif

interface wb_unit_if #(
  parameter int unsigned W = 32
);
  // Memory-stage slot
  logic                         in_valid;
  logic                         in_ready;
  logic                         flush;
  logic                         reg_write_en;
  logic [`REG_W_SRC_WIDTH-1:0]  reg_write_src;
  logic [`REG_W_DST_WIDTH-1:0]  reg_write_dst;
  logic [`REG_ADDR_W-1:0]       rd;
  logic [`REG_ADDR_W-1:0]       rt;
  logic [W-1:0]                 alu_result;
  logic [W-1:0]                 mem_data;
  logic [W-1:0]                 pc;
  logic [1:0]                   mem_size;
  logic                         mem_signed;
  logic [1:0]                   mem_addr_lo;
  // Long-latency result port
  logic                         late_valid;
  logic                         late_ready;
  logic [`REG_ADDR_W-1:0]       late_addr;
  logic [W-1:0]                 late_data;
  // Register-file write port
  logic                         wb_en;
  logic [`REG_ADDR_W-1:0]       wb_addr;
  logic [W-1:0]                 wb_data;

  modport master (
    output in_valid, flush, reg_write_en, reg_write_src, reg_write_dst, rd, rt,
           alu_result, mem_data, pc, mem_size, mem_signed, mem_addr_lo,
           late_valid, late_addr, late_data,
    input  in_ready, late_ready, wb_en, wb_addr, wb_data
  );

  modport slave (
    input  in_valid, flush, reg_write_en, reg_write_src, reg_write_dst, rd, rt,
           alu_result, mem_data, pc, mem_size, mem_signed, mem_addr_lo,
           late_valid, late_addr, late_data,
    output in_ready, late_ready, wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/wb_unit.sv
// Registered MIPS32 writeback stage.
// Holds one MEM/WB slot (address and data already resolved, loads already aligned and
// extended) and a small FIFO of long-latency results. A fixed-priority arbiter gives
// the single register-file write port to the stage slot first, then to the FIFO head.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - wb_unit_if.slave: memory-stage slot in, late results in, write port out

module wb_unit #(
  parameter int unsigned W          = 32,
  parameter int unsigned LATE_DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  wb_unit_if.slave  bus
);

  localparam int unsigned AW = `REG_ADDR_W;
  localparam int unsigned PW = $clog2(LATE_DEPTH);
  localparam int unsigned CW = PW + 1;

  // Stage register
  logic          r_valid;
  logic [AW-1:0] r_addr;
  logic [W-1:0]  r_data;

  // Late-result FIFO
  logic [AW-1:0] r_fifo_addr [LATE_DEPTH];
  logic [W-1:0]  r_fifo_data [LATE_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_addr;
  logic [W-1:0]  w_data;
  logic [W-1:0]  w_load;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic          w_slot_writes;

  assign w_full  = (r_count == CW'(LATE_DEPTH));
  assign w_empty = (r_count == '0);

  assign bus.in_ready   = !w_full;
  assign bus.late_ready = !w_full;

  // Destination resolution
  always_comb begin
    w_addr = '0;
    case (bus.reg_write_dst)
      `REG_W_DST_RD:  w_addr = bus.rd;
      `REG_W_DST_RT:  w_addr = bus.rt;
      `REG_W_DST_R31: w_addr = AW'(31);
      default:        w_addr = '0;
    endcase
  end

  // Little-endian load lane select and extension
  always_comb begin
    w_byte = 8'h00;
    unique case (bus.mem_addr_lo)
      2'd0: w_byte = bus.mem_data[7:0];
      2'd1: w_byte = bus.mem_data[15:8];
      2'd2: w_byte = bus.mem_data[23:16];
      2'd3: w_byte = bus.mem_data[31:24];
    endcase
    w_half = bus.mem_addr_lo[1] ? bus.mem_data[31:16] : bus.mem_data[15:0];
    case (bus.mem_size)
      2'b10:   w_load = bus.mem_signed ? {{(W-8){w_byte[7]}}, w_byte}
                                       : {{(W-8){1'b0}}, w_byte};
      2'b01:   w_load = bus.mem_signed ? {{(W-16){w_half[15]}}, w_half}
                                       : {{(W-16){1'b0}}, w_half};
      default: w_load = bus.mem_data;
    endcase
  end

  // Data resolution
  always_comb begin
    w_data = '0;
    case (bus.reg_write_src)
      `REG_W_SRC_ALU:  w_data = bus.alu_result;
      `REG_W_SRC_MEM:  w_data = w_load;
      `REG_W_SRC_PCA4: w_data = bus.pc + W'(4);
      default:         w_data = '0;
    endcase
  end

  // Non-writing slots are folded into valid=0 so the arbiter only checks one bit.
  assign w_slot_writes = bus.in_valid && !bus.flush && bus.reg_write_en && (w_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (!w_full) begin
      r_valid <= w_slot_writes;
      r_addr  <= w_addr;
      r_data  <= w_data;
    end else begin
      // Bubble while the FIFO is full so it can drain; upstream holds its slot.
      r_valid <= 1'b0;
    end
  end

  // Address-0 late results are acknowledged but never stored.
  assign w_push = bus.late_valid && !w_full && (bus.late_addr != '0);
  assign w_pop  = !r_valid && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= bus.late_addr;
      r_fifo_data[r_wr_ptr] <= bus.late_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Fixed-priority write-port arbiter
  always_comb begin
    bus.wb_en   = 1'b0;
    bus.wb_addr = '0;
    bus.wb_data = '0;
    if (r_valid) begin
      bus.wb_en   = 1'b1;
      bus.wb_addr = r_addr;
      bus.wb_data = r_data;
    end else if (!w_empty) begin
      bus.wb_en   = 1'b1;
      bus.wb_addr = r_fifo_addr[r_rd_ptr];
      bus.wb_data = r_fifo_data[r_rd_ptr];
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: reset values, load alignment/extension, JAL and RT
// destinations, late-result arbitration and FIFO back-pressure, flush, mid-run reset.

`ifndef WB_UNIT_DEFINES
`define WB_UNIT_DEFINES
`define REG_ADDR_W      5
`define REG_W_SRC_WIDTH 2
`define REG_W_DST_WIDTH 2
`define REG_W_SRC_ALU   2'b00
`define REG_W_SRC_MEM   2'b01
`define REG_W_SRC_PCA4  2'b10
`define REG_W_DST_RD    2'b00
`define REG_W_DST_RT    2'b01
`define REG_W_DST_R31   2'b10
`endif

module tb_wb_unit;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  wb_unit_if #(.W(32)) bus ();

  wb_unit #(.W(32), .LATE_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_wb(input string tag, input logic en, input logic [4:0] addr,
                          input logic [31:0] data);
    check({tag, ".en"}, {31'd0, bus.wb_en}, {31'd0, en});
    check({tag, ".addr"}, {27'd0, bus.wb_addr}, {27'd0, addr});
    check({tag, ".data"}, bus.wb_data, data);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid      = 1'b0;
    bus.flush         = 1'b0;
    bus.reg_write_en  = 1'b0;
    bus.reg_write_src = `REG_W_SRC_ALU;
    bus.reg_write_dst = `REG_W_DST_RD;
    bus.rd            = '0;
    bus.rt            = '0;
    bus.alu_result    = '0;
    bus.mem_data      = '0;
    bus.pc            = '0;
    bus.mem_size      = 2'b00;
    bus.mem_signed    = 1'b0;
    bus.mem_addr_lo   = 2'b00;
    bus.late_valid    = 1'b0;
    bus.late_addr     = '0;
    bus.late_data     = '0;
  endtask

  task automatic alu_slot(input logic [4:0] rd_v, input logic [31:0] val);
    bus.in_valid      = 1'b1;
    bus.reg_write_en  = 1'b1;
    bus.reg_write_src = `REG_W_SRC_ALU;
    bus.reg_write_dst = `REG_W_DST_RD;
    bus.rd            = rd_v;
    bus.alu_result    = val;
  endtask

  task automatic load_slot(input logic [1:0] size, input logic sgn, input logic [1:0] lo);
    bus.in_valid      = 1'b1;
    bus.reg_write_en  = 1'b1;
    bus.reg_write_src = `REG_W_SRC_MEM;
    bus.reg_write_dst = `REG_W_DST_RD;
    bus.rd            = 5'd3;
    bus.mem_data      = 32'h8070_F0A5;
    bus.mem_size      = size;
    bus.mem_signed    = sgn;
    bus.mem_addr_lo   = lo;
  endtask

  task automatic late(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.late_valid = v;
    bus.late_addr  = a;
    bus.late_data  = d;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    rst = 1'b1;
    #2;
    check_wb("reset", 1'b0, 5'd0, 32'h0);
    check("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset.late_ready", {31'd0, bus.late_ready}, 32'd1);
    #10 rst = 1'b0;

    // Load alignment and extension
    load_slot(2'b10, 1'b1, 2'd2);
    tick(); check_wb("lb_lo2", 1'b1, 5'd3, 32'h0000_0070);
    load_slot(2'b10, 1'b1, 2'd0);
    tick(); check_wb("lb_lo0", 1'b1, 5'd3, 32'hFFFF_FFA5);
    load_slot(2'b01, 1'b0, 2'd3);
    tick(); check_wb("lhu_lo3", 1'b1, 5'd3, 32'h0000_8070);
    load_slot(2'b01, 1'b1, 2'd1);
    tick(); check_wb("lh_lo1", 1'b1, 5'd3, 32'hFFFF_F0A5);
    load_slot(2'b10, 1'b0, 2'd3);
    tick(); check_wb("lbu_lo3", 1'b1, 5'd3, 32'h0000_0080);
    load_slot(2'b11, 1'b1, 2'd2);
    tick(); check_wb("lw_size3", 1'b1, 5'd3, 32'h8070_F0A5);

    // JAL, RD=0, RT destination, reg_write_en=0
    idle();
    bus.in_valid = 1'b1; bus.reg_write_en = 1'b1;
    bus.reg_write_src = `REG_W_SRC_PCA4; bus.reg_write_dst = `REG_W_DST_R31;
    bus.pc = 32'h0040_0010;
    tick(); check_wb("jal", 1'b1, 5'd31, 32'h0040_0014);
    idle(); alu_slot(5'd0, 32'h1111_1111);
    tick(); check_wb("rd_zero", 1'b0, 5'd0, 32'h0);
    idle(); alu_slot(5'd0, 32'h0000_1234);
    bus.reg_write_dst = `REG_W_DST_RT; bus.rt = 5'd7;
    tick(); check_wb("rt_dst", 1'b1, 5'd7, 32'h0000_1234);
    idle(); alu_slot(5'd8, 32'h5555_5555); bus.reg_write_en = 1'b0;
    tick(); check_wb("no_we", 1'b0, 5'd0, 32'h0);

    // Late result held behind four pipeline writes
    idle(); alu_slot(5'd9, 32'd1); late(1'b1, 5'd5, 32'hDEAD_BEEF);
    tick(); check_wb("late_hold1", 1'b1, 5'd9, 32'd1);
    late(1'b0, 5'd0, 32'h0); alu_slot(5'd9, 32'd2);
    tick(); check_wb("late_hold2", 1'b1, 5'd9, 32'd2);
    alu_slot(5'd9, 32'd3);
    tick(); check_wb("late_hold3", 1'b1, 5'd9, 32'd3);
    alu_slot(5'd9, 32'd4);
    tick(); check_wb("late_hold4", 1'b1, 5'd9, 32'd4);
    idle();
    tick(); check_wb("late_emit", 1'b1, 5'd5, 32'hDEAD_BEEF);
    tick(); check_wb("late_done", 1'b0, 5'd0, 32'h0);

    // Address-0 late result is dropped
    late(1'b1, 5'd0, 32'h7777_7777);
    tick(); check_wb("late_addr0", 1'b0, 5'd0, 32'h0);
    idle();

    // Fill FIFO under continuous pipeline writes, then drain
    alu_slot(5'd9, 32'hA0);
    for (int i = 0; i < 4; i++) begin
      late(1'b1, 5'(11 + i), 32'h100 + 32'(i + 1));
      tick();
      check_wb("fill_pipe", 1'b1, 5'd9, 32'hA0);
      check("fill.late_ready", {31'd0, bus.late_ready}, (i == 3) ? 32'd0 : 32'd1);
      check("fill.in_ready", {31'd0, bus.in_ready}, (i == 3) ? 32'd0 : 32'd1);
    end
    late(1'b1, 5'd15, 32'h105);
    tick(); check_wb("full_head", 1'b1, 5'd11, 32'h101);
    check("full.late_ready", {31'd0, bus.late_ready}, 32'd0);
    tick(); check_wb("drain_12", 1'b1, 5'd12, 32'h102);
    check("drain.late_ready", {31'd0, bus.late_ready}, 32'd1);
    check("drain.in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick(); check_wb("fifth_pipe", 1'b1, 5'd9, 32'hA0);
    idle();
    tick(); check_wb("drain_13", 1'b1, 5'd13, 32'h103);
    tick(); check_wb("drain_14", 1'b1, 5'd14, 32'h104);
    tick(); check_wb("drain_15", 1'b1, 5'd15, 32'h105);
    tick(); check_wb("drain_empty", 1'b0, 5'd0, 32'h0);

    // Flush: the queued late result takes the port instead
    alu_slot(5'd9, 32'hB0); late(1'b1, 5'd20, 32'h0000_CAFE);
    tick(); check_wb("flush_pre", 1'b1, 5'd9, 32'hB0);
    late(1'b0, 5'd0, 32'h0); alu_slot(5'd10, 32'hB1); bus.flush = 1'b1;
    tick(); check_wb("flush_late", 1'b1, 5'd20, 32'h0000_CAFE);
    idle();
    tick(); check_wb("flush_done", 1'b0, 5'd0, 32'h0);

    // Reset mid-stream with three entries queued
    alu_slot(5'd9, 32'hC0);
    for (int i = 0; i < 3; i++) begin
      late(1'b1, 5'(21 + i), 32'h200 + 32'(i));
      tick();
    end
    check_wb("pre_reset", 1'b1, 5'd9, 32'hC0);
    idle();
    rst = 1'b1;
    #1;
    check_wb("mid_reset", 1'b0, 5'd0, 32'h0);
    #2 rst = 1'b0;
    check("post_reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("post_reset.late_ready", {31'd0, bus.late_ready}, 32'd1);
    tick(); check_wb("post_reset_empty", 1'b0, 5'd0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
